// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Consumed by fetch_fifo and fetch_controller (optional macro FETCH_PERF_CNT_EN lives in the top).
package fetch_pkg;

    localparam int unsigned         INSTR_W        = 16;
    localparam int unsigned         FETCH_ADDR_W   = 16;
    localparam logic [15:0]         FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs with push/pop/flush.
// Head is presented combinationally from storage; occupancy is exported for issue throttling.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [ADDR_W-1:0]         i_push_pc,
    input  logic [INSTR_W-1:0]        i_push_instr,
    input  logic                      i_pop,
    input  logic                      i_flush,
    output logic [ADDR_W-1:0]         o_head_pc,
    output logic [INSTR_W-1:0]        o_head_instr,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign w_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_push = i_push && !i_flush && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, strobes instruction memory, buffers returns, feeds decode.
// Define FETCH_PERF_CNT_EN to add saturating stall/fetch counters (D_StallCount, D_FetchCount).
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   A_InstrAddress,
    output logic                C_IMRead,
    input  logic [INSTR_W-1:0]  D_Instruction,
    input  logic                C_Redirect,
    input  logic [ADDR_W-1:0]   A_RedirectTarget,
    input  logic                C_Halt,
    output logic [INSTR_W-1:0]  D_IfInstr,
    output logic [ADDR_W-1:0]   A_IfPC,
    output logic                C_IfValid,
    input  logic                C_IdReady,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]         D_StallCount,
    output logic [15:0]         D_FetchCount,
`endif
    output logic                C_Idle
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_tag;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_hold_pc;
    logic [INSTR_W-1:0]  r_hold_instr;

    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_occupancy;
    logic                w_empty;
    logic                w_deq;
    logic                w_issue;
    logic                w_push;
    logic [ADDR_W-1:0]   w_head_pc;
    logic [INSTR_W-1:0]  w_head_instr;

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_pc    (r_tag),
        .i_push_instr (D_Instruction),
        .i_pop        (w_deq),
        .i_flush      (C_Redirect),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    assign w_deq  = !w_empty && C_IdReady;
    assign w_push = r_inflight && !C_Redirect;

    // The in-flight word already owns a slot; a same-cycle pop frees one.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                       - {{CNT_W{1'b0}}, w_deq};
    assign w_issue     = !rst && (r_state == ST_RUN) && !C_Redirect && !C_Halt
                       && (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_tag        <= '0;
            r_inflight   <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (C_Redirect) begin
                r_pc <= A_RedirectTarget;
            end else if (w_issue) begin
                r_tag <= r_pc;
                r_pc  <= r_pc + 1'b1;
            end
            if (!w_empty) begin
                r_hold_pc    <= w_head_pc;
                r_hold_instr <= w_head_instr;
            end
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  if (C_Halt)  r_state <= ST_HALT;
                ST_HALT: if (!C_Halt) r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign A_InstrAddress = r_pc;
    assign C_IMRead       = w_issue;
    assign C_IfValid      = !w_empty;
    assign D_IfInstr      = w_empty ? r_hold_instr : w_head_instr;
    assign A_IfPC         = w_empty ? r_hold_pc    : w_head_pc;
    assign C_Idle         = (r_state == ST_HALT) && w_empty && !r_inflight;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fetch_cnt <= '0;
        end else begin
            if (C_IfValid && !C_IdReady && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_issue && (r_fetch_cnt != '1))                 r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
    end

    assign D_StallCount = r_stall_cnt;
    assign D_FetchCount = r_fetch_cnt;
`endif

endmodule
